jump_control: RTL
=================

JUMP_CONTROL -- requirements
Module: jump_control

Interface
REQ-001 Parameter FLUSH_CYCLES SHALL be: default 2, range 1-7; number of cycles flush stays high after a jump is acknowledged.
REQ-002 Parameter ACK_TIMEOUT SHALL be: default 4, range 2-15; maximum cycles in ISSUE before the request is abandoned.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 instr_valid  input  1  opcode/target valid this cycle.
REQ-006 opcode  input  4  4'b1000 JMP absolute, 4'b1001 BEQ relative, 4'b1010 BNE relative; all other values are non-jump.
REQ-007 target  input  8  absolute address (JMP) or two's-complement offset (BEQ/BNE).
REQ-008 flag_zero  input  1  ALU zero flag, sampled with instr_valid.
REQ-009 pc_in  input  8  current program counter value, sampled with instr_valid.
REQ-010 jumped  input  1  acknowledge from the program counter: its pc was loaded from jump_data.
REQ-011 jump  output  1  jump request to the program counter.
REQ-012 jump_data  output  8  jump target address, stable while jump=1.
REQ-013 instr_ready  output  1  high only in IDLE; instructions are accepted only when high.
REQ-014 flush  output  1  squash in-flight pipeline stages.
REQ-015 err  output  1  sticky; acknowledge timeout occurred.
REQ-016 jump_count  output  8  count of acknowledged jumps; wraps 255->0.

Function
REQ-017 The block SHALL implement states IDLE, ISSUE and FLUSH, with all outputs registered.
REQ-018 Taken condition: JMP is always taken; BEQ is taken when flag_zero=1; BNE is taken when flag_zero=0.
REQ-019 In IDLE, when instr_valid=1 and the instruction is taken, at the next edge the block SHALL:
 - load jump_data (JMP: target; BEQ/BNE: pc_in + target, 8-bit modulo 256, sign-extended offset);
 - set jump=1 and instr_ready=0;
 - enter ISSUE.
REQ-020 In IDLE, a not-taken or non-jump instruction SHALL cause no state or output change; instr_ready stays 1.
REQ-021 instr_valid in ISSUE or FLUSH SHALL be ignored (no queuing).
REQ-022 ISSUE SHALL:
 - hold jump=1 and jump_data constant;
 - ignore jumped during its first cycle, because the value may be stale;
 - from the second cycle on, at the edge where jumped=1 is sampled: jump=0, flush=1, jump_count+1, enter FLUSH.
REQ-023 If jumped is not sampled high within ACK_TIMEOUT cycles of entering ISSUE, the block SHALL set jump=0 and err=1, then enter IDLE with no flush.
REQ-024 FLUSH SHALL hold flush=1 for exactly FLUSH_CYCLES cycles, then return to IDLE with flush=0 and instr_ready=1.
REQ-025 jump SHALL be held through full clock periods so that a program counter sampling on the falling edge sees a stable request.
REQ-026 Latency: taken instruction accepted at edge N -> jump=1 after N -> earliest flush=1 after edge N+2.
REQ-027 err SHALL remain 1 until reset; operation SHALL continue normally after err is set.

Reset
REQ-028 While reset=1, regardless of clock, outputs SHALL be:
 - jump=0, jump_data=8'h00, flush=0, err=0, jump_count=8'h00;
 - instr_ready=1; state=IDLE.
REQ-029 Reset asserted in ISSUE or FLUSH SHALL abort the operation immediately with no further flush cycles.
REQ-030 After reset deasserts, the first rising edge SHALL be able to accept an instruction.

Verification
REQ-031 JMP target=8'h40, pc_in=8'h10, jumped high 1 cycle after jump -> jump_data=8'h40; flush high 2 cycles; jump_count=1; instr_ready back to 1.
REQ-032 BEQ flag_zero=1, pc_in=8'hFE, target=8'h05 -> jump_data=8'h03 (wrap); BEQ flag_zero=0 -> jump stays 0, instr_ready stays 1.
REQ-033 BNE pc_in=8'h20, target=8'hF0 (-16), flag_zero=0 -> jump_data=8'h10.
REQ-034 JMP with jumped held 0 -> jump drops after 4 cycles; err=1; flush never asserted; a following JMP completes normally with err still 1.
REQ-035 JMP accepted, then reset pulsed during FLUSH -> all outputs at reset values asynchronously; no residual flush after release.
REQ-036 instr_valid pulses with taken JMP during ISSUE and FLUSH -> ignored; exactly one jump and jump_count=1.

Source files
------------

// File: rtl/jump_control.sv
// -----------------------------------------------------------------------------
// jump_control
//
// Turns jump/branch instructions into a handshaked jump request for the
// program counter, then squashes the pipeline once the jump has been taken.
//
//   IDLE  : accepts one instruction per cycle while instr_ready=1. A taken
//           JMP/BEQ/BNE latches its destination and raises jump.
//   ISSUE : holds jump/jump_data. The acknowledge (jumped) is ignored in the
//           first ISSUE cycle, because it may still reflect an older request.
//           An acknowledge ends ISSUE and starts the flush. If no acknowledge
//           arrives within ACK_TIMEOUT cycles, the request is abandoned and
//           the sticky err flag is set.
//   FLUSH : holds flush for FLUSH_CYCLES cycles, then returns to IDLE.
//
// Parameters
//   FLUSH_CYCLES : flush length in cycles (1..7)
//   ACK_TIMEOUT  : maximum ISSUE length in cycles (2..15)
//
// Ports
//   clock, reset          : single clock; asynchronous active-high reset
//   instr_valid           : opcode/target/flag_zero/pc_in are valid
//   opcode[3:0]           : 1000 JMP, 1001 BEQ, 1010 BNE; all others are non-jump
//   target[7:0]           : absolute address (JMP) or signed offset (BEQ/BNE)
//   flag_zero             : ALU zero flag
//   pc_in[7:0]            : current program counter
//   jumped                : program counter has loaded jump_data
//   jump                  : jump request (registered)
//   jump_data[7:0]        : jump destination, stable while jump=1
//   instr_ready           : high only in IDLE
//   flush                 : squash in-flight pipeline stages
//   err                   : sticky acknowledge-timeout flag
//   jump_count[7:0]       : acknowledged jumps, wraps 255->0
// -----------------------------------------------------------------------------
module jump_control #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [3:0] opcode,
  input  logic [7:0] target,
  input  logic       flag_zero,
  input  logic [7:0] pc_in,
  input  logic       jumped,
  output logic       jump,
  output logic [7:0] jump_data,
  output logic       instr_ready,
  output logic       flush,
  output logic       err,
  output logic [7:0] jump_count
);

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);
  localparam logic [3:0] ACK_LAST   = 4'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH
  } state_t;

  state_t     state;
  // Number of the cycle currently being spent in ISSUE or FLUSH (1-based).
  logic [3:0] cnt;

  logic       taken;
  logic [7:0] dest;

  // NOTE: every signal driven here gets a default value first, so that no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_JMP:  taken = 1'b1;
      OP_BEQ:  taken = flag_zero;
      OP_BNE:  taken = ~flag_zero;
      default: taken = 1'b0;
    endcase
    // An 8-bit add is the same as adding the sign-extended offset modulo 256.
    dest = (opcode == OP_JMP) ? target : pc_in + target;
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of the order
  // of the statements.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      jump        <= 1'b0;
      jump_data   <= '0;
      instr_ready <= 1'b1;
      flush       <= 1'b0;
      err         <= 1'b0;
      jump_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid && taken) begin
            jump_data   <= dest;
            jump        <= 1'b1;
            instr_ready <= 1'b0;
            cnt         <= 4'd1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          // cnt=1 is the first ISSUE cycle, where jumped may be stale.
          if (cnt >= 4'd2 && jumped) begin
            jump       <= 1'b0;
            flush      <= 1'b1;
            jump_count <= jump_count + 8'd1;
            cnt        <= 4'd1;
            state      <= FLUSH;
          end else if (cnt == ACK_LAST) begin
            jump        <= 1'b0;
            err         <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            flush       <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
